// File: rtl/int_service_master.sv
// Wishbone master that services a level interrupt controller. It programs IER/MER at
// start-up, reads IPR on irq, presents the lowest pending vector and acknowledges it via IAR.
module int_service_master #(
  parameter int                 INT_NUM     = 32,
  parameter int                 DATA_WIDTH  = 32,
  parameter int                 SEL_WIDTH   = 4,
  parameter int                 ADDR_WIDTH  = 3,
  parameter logic [INT_NUM-1:0] IER_INIT    = '1,
  parameter int                 ACK_TIMEOUT = 15,
  localparam int                VEC_WIDTH   = (INT_NUM > 1) ? $clog2(INT_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] m_dat_o,
  output logic [SEL_WIDTH-1:0]  m_sel_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic                  m_stb_o,
  output logic                  m_we_o,
  input  logic [DATA_WIDTH-1:0] m_dat_i,
  input  logic                  m_ack_i,
  input  logic                  irq_i,
  output logic [VEC_WIDTH-1:0]  vec_o,
  output logic                  vec_valid_o,
  input  logic                  vec_ready_i,
  output logic                  err_o,
  output logic                  spurious_o
);

  typedef enum logic [2:0] {
    ST_INIT_IER, ST_INIT_MER, ST_IDLE, ST_RD_IPR, ST_PRESENT, ST_WR_IAR
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MER  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IER  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IAR  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IPR  = ADDR_WIDTH'(3);
  localparam logic [7:0]            LAST_WAIT = 8'(ACK_TIMEOUT - 1);

  state_e                  r_state, w_state_nxt;
  logic                    r_stb, w_stb_nxt;
  logic                    r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_dat, w_dat_nxt;
  logic [SEL_WIDTH-1:0]    r_sel, w_sel_nxt;
  logic [VEC_WIDTH-1:0]    r_vec, w_vec_nxt;
  logic                    r_vec_valid, w_vec_valid_nxt;
  logic                    r_err, w_err_nxt;
  logic                    r_spurious, w_spurious_nxt;
  logic [7:0]              r_cnt, w_cnt_nxt;
  logic [INT_NUM-1:0]      r_mask, w_mask_nxt;

  logic                    w_done, w_timeout;
  logic                    w_req, w_req_we;
  logic [ADDR_WIDTH-1:0]   w_req_addr;
  logic [DATA_WIDTH-1:0]   w_req_dat;
  logic [INT_NUM-1:0]      w_ipr, w_low_mask;
  logic [VEC_WIDTH-1:0]    w_low_idx;

  assign w_done    = r_stb & m_ack_i;
  assign w_timeout = r_stb & ~m_ack_i & (r_cnt >= LAST_WAIT);

  // Lowest pending line wins: isolate its one-hot mask and encode its index.
  always_comb begin
    w_ipr      = m_dat_i[INT_NUM-1:0];
    w_low_mask = w_ipr & (~w_ipr + INT_NUM'(1));
    w_low_idx  = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (w_ipr[i]) w_low_idx = VEC_WIDTH'(i);
    end
  end

  // NOTE: every signal gets its default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_stb_nxt       = r_stb;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_dat_nxt       = r_dat;
    w_sel_nxt       = r_sel;
    w_vec_nxt       = r_vec;
    w_vec_valid_nxt = r_vec_valid;
    w_err_nxt       = r_err;
    w_spurious_nxt  = 1'b0;
    w_cnt_nxt       = r_cnt;
    w_mask_nxt      = r_mask;
    w_req           = 1'b0;
    w_req_we        = 1'b0;
    w_req_addr      = '0;
    w_req_dat       = '0;

    unique case (r_state)
      ST_INIT_IER: begin
        w_req     = 1'b1;
        w_req_we  = 1'b1;
        w_req_addr = ADDR_IER;
        w_req_dat = DATA_WIDTH'(IER_INIT);
        if (w_done) w_state_nxt = ST_INIT_MER;
      end
      ST_INIT_MER: begin
        w_req      = 1'b1;
        w_req_we   = 1'b1;
        w_req_addr = ADDR_MER;
        w_req_dat  = DATA_WIDTH'(2'b11);
        if (w_done) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (irq_i) w_state_nxt = ST_RD_IPR;
      end
      ST_RD_IPR: begin
        w_req      = 1'b1;
        w_req_addr = ADDR_IPR;
        if (w_done) begin
          if (|w_ipr) begin
            w_state_nxt     = ST_PRESENT;
            w_vec_nxt       = w_low_idx;
            w_mask_nxt      = w_low_mask;
            w_vec_valid_nxt = 1'b1;
          end else begin
            w_spurious_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
          end
        end
      end
      ST_PRESENT: begin
        if (vec_ready_i) begin
          w_vec_valid_nxt = 1'b0;
          w_state_nxt     = ST_WR_IAR;
        end
      end
      ST_WR_IAR: begin
        w_req      = 1'b1;
        w_req_we   = 1'b1;
        w_req_addr = ADDR_IAR;
        w_req_dat  = DATA_WIDTH'(r_mask);
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT_IER;
    endcase

    // Shared bus engine: issue when idle, hold until ack, never strobe back-to-back.
    if (!r_stb) begin
      if (w_req) begin
        w_stb_nxt  = 1'b1;
        w_we_nxt   = w_req_we;
        w_addr_nxt = w_req_addr;
        w_dat_nxt  = w_req_dat;
        w_sel_nxt  = '1;
        w_cnt_nxt  = '0;
      end
    end else if (m_ack_i || w_timeout) begin
      w_stb_nxt = 1'b0;
      w_we_nxt  = 1'b0;
      w_sel_nxt = '0;
      w_cnt_nxt = '0;
      if (w_timeout) begin
        w_err_nxt = 1'b1;
        // Start-up writes are retried; service accesses give up and return to IDLE.
        if (r_state != ST_INIT_IER && r_state != ST_INIT_MER) w_state_nxt = ST_IDLE;
      end
    end else begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_INIT_IER;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
      r_err       <= 1'b0;
      r_spurious  <= 1'b0;
      r_cnt       <= '0;
      r_mask      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stb       <= w_stb_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_dat       <= w_dat_nxt;
      r_sel       <= w_sel_nxt;
      r_vec       <= w_vec_nxt;
      r_vec_valid <= w_vec_valid_nxt;
      r_err       <= w_err_nxt;
      r_spurious  <= w_spurious_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mask      <= w_mask_nxt;
    end
  end

  assign m_stb_o     = r_stb;
  assign m_we_o      = r_we;
  assign m_addr_o    = r_addr;
  assign m_dat_o     = r_dat;
  assign m_sel_o     = r_sel;
  assign vec_o       = r_vec;
  assign vec_valid_o = r_vec_valid;
  assign err_o       = r_err;
  assign spurious_o  = r_spurious;

endmodule

// File: tb/tb_int_service_master.sv
// Randomised bench for int_service_master: a slave model answers bus accesses, a scoreboard
// queue holds the expected bus/vector/spurious events and a monitor consumes them in order.
module tb_int_service_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;
  logic [2:0]  m_addr_o;
  logic        m_stb_o, m_we_o, m_ack_i;
  logic        irq_i, vec_valid_o, vec_ready_i, err_o, spurious_o;
  logic [4:0]  vec_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int_service_master dut (
    .clk(clk), .reset(rst),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_addr_o(m_addr_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .irq_i(irq_i),
    .vec_o(vec_o), .vec_valid_o(vec_valid_o), .vec_ready_i(vec_ready_i),
    .err_o(err_o), .spurious_o(spurious_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef enum {EV_BUS, EV_VEC, EV_SPUR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] dat;
  } ev_t;
  ev_t exp_q[$];

  function automatic int lowest_set(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push_ev(input ev_kind_e k, input logic we, input logic [2:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.we = we; e.addr = a; e.dat = d;
    exp_q.push_back(e);
  endtask

  // One interrupt service: IPR read, then either a vector plus IAR write of its bit, or a spurious pulse.
  task automatic push_service(input logic [31:0] ipr, input bit with_iar);
    int idx;
    idx = lowest_set(ipr);
    push_ev(EV_BUS, 1'b0, 3'd3, 32'h0);
    if (idx < 0) begin
      push_ev(EV_SPUR, 1'b0, 3'd0, 32'h0);
    end else begin
      push_ev(EV_VEC, 1'b0, 3'd0, 32'(idx));
      if (with_iar) push_ev(EV_BUS, 1'b1, 3'd2, 32'h1 << idx);
    end
  endtask

  task automatic take_ev(input ev_kind_e k, output ev_t e, output bit ok);
    e.kind = k; e.we = 1'b0; e.addr = '0; e.dat = '0;
    ok = (exp_q.size() > 0) && (exp_q[0].kind == k);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL event_order: got %s, expected %s", k.name(),
               (exp_q.size() > 0) ? exp_q[0].kind.name() : "nothing");
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  // ---------------- slave model ----------------
  bit          no_ack    = 1'b0;
  int          max_delay = 0;
  logic [31:0] ipr_val   = '0;

  initial begin
    int delay, waited;
    delay = 0; waited = 0;
    m_ack_i = 1'b0; m_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || m_ack_i || !m_stb_o || no_ack) begin
        m_ack_i = 1'b0;
        waited  = 0;
      end else if (waited >= delay) begin
        m_ack_i = 1'b1;
        m_dat_i = m_we_o ? $urandom : ipr_val;
        waited  = 0;
        delay   = $urandom_range(0, max_delay);
      end else begin
        waited++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit   prev_xfer, prev_hs, prev_spur, ok;
    ev_t  e;
    prev_xfer = 0; prev_hs = 0; prev_spur = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_xfer = 0; prev_hs = 0; prev_spur = 0;
      end else begin
        if (prev_xfer) check("stb_gap_after_ack", 32'(m_stb_o), 32'h0);
        if (prev_hs)   check("valid_drop_after_hs", 32'(vec_valid_o), 32'h0);
        prev_xfer = 0; prev_hs = 0;
        if (m_stb_o && m_ack_i) begin
          prev_xfer = 1;
          check("bus_sel", 32'(m_sel_o), 32'hF);
          take_ev(EV_BUS, e, ok);
          if (ok) begin
            check("bus_we", 32'(m_we_o), 32'(e.we));
            check("bus_addr", 32'(m_addr_o), 32'(e.addr));
            if (e.we) check("bus_wdata", m_dat_o, e.dat);
          end
        end
        if (vec_valid_o && vec_ready_i) begin
          prev_hs = 1;
          take_ev(EV_VEC, e, ok);
          if (ok) check("vec_value", 32'(vec_o), e.dat);
        end
        if (spurious_o) begin
          check("spurious_one_cycle", 32'(prev_spur), 32'h0);
          take_ev(EV_SPUR, e, ok);
        end
        prev_spur = spurious_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_quiet(input string name);
    bit done;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      done = (exp_q.size() == 0) && !m_stb_o && !vec_valid_o;
    end
    check(name, 32'(exp_q.size()), 32'h0);
    tick(); tick();
  endtask

  task automatic wait_rd_issue(output bit ok);
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      ok = m_stb_o && (m_addr_o == 3'd3) && !m_we_o;
    end
    check("ipr_read_issued", 32'(ok), 32'h1);
  endtask

  task automatic service(input logic [31:0] ipr, input int ready_delay, input bit wild_irq);
    bit         ok;
    logic [4:0] v0;
    ipr_val = ipr;
    push_service(ipr, 1'b1);
    irq_i = 1'b1;
    wait_rd_issue(ok);
    irq_i = 1'b0;
    if (ipr != 0) begin
      ok = 0;
      for (int k = 0; k < 30 && !ok; k++) begin
        if (!vec_valid_o) tick();
        ok = vec_valid_o;
      end
      check("vec_valid_rise", 32'(ok), 32'h1);
      v0 = vec_o;
      for (int d = 0; d < ready_delay; d++) begin
        if (wild_irq) irq_i = 1'($urandom);
        tick();
        check("bp_valid_held", 32'(vec_valid_o), 32'h1);
        check("bp_vec_stable", 32'(vec_o), 32'(v0));
        check("bp_no_bus", 32'(m_stb_o), 32'h0);
      end
      irq_i = 1'b0;
      vec_ready_i = 1'b1;
      tick();
      vec_ready_i = 1'b0;
    end
    wait_quiet("service_drain");
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          run;
    logic [31:0] val;
    irq_i = 1'b0; vec_ready_i = 1'b0;

    #1;
    check("rst_stb", 32'(m_stb_o), 32'h0);
    check("rst_we", 32'(m_we_o), 32'h0);
    check("rst_addr", 32'(m_addr_o), 32'h0);
    check("rst_dat", m_dat_o, 32'h0);
    check("rst_sel", 32'(m_sel_o), 32'h0);
    check("rst_vec", 32'(vec_o), 32'h0);
    check("rst_vec_valid", 32'(vec_valid_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_spurious", 32'(spurious_o), 32'h0);

    // Start-up: IER := all ones, then MER := 3, slave acks one cycle after strobe.
    push_ev(EV_BUS, 1'b1, 3'd1, 32'hFFFF_FFFF);
    push_ev(EV_BUS, 1'b1, 3'd0, 32'h0000_0003);
    @(posedge clk); #3 rst = 1'b0;
    tick();
    check("first_issue_stb", 32'(m_stb_o), 32'h1);
    check("first_issue_addr", 32'(m_addr_o), 32'h1);
    wait_quiet("startup_drain");
    max_delay = 3;

    // Idle: ready without a pending vector is ignored.
    vec_ready_i = 1'b1;
    repeat (3) tick();
    check("idle_ready_no_valid", 32'(vec_valid_o), 32'h0);
    check("idle_ready_no_bus", 32'(m_stb_o), 32'h0);
    vec_ready_i = 1'b0;

    service(32'h0000_0014, 0, 1'b0);              // vector 2, IAR data 4
    service(32'h8000_0100, 10, 1'b1);             // backpressure with irq noise
    service(32'h0000_0000, 0, 1'b0);              // spurious
    service(32'h8000_0000, 1, 1'b0);              // highest line

    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 3))
        0:       val = 32'h1 << $urandom_range(0, 31);
        1:       val = $urandom;
        2:       val = $urandom & $urandom & $urandom;
        default: val = $urandom & 32'hFFFF_0000;
      endcase
      service(val, $urandom_range(0, 4), 1'b1);
    end

    // Timeout on the IPR read: strobe exactly 15 cycles, sticky error, no retry.
    no_ack = 1'b1;
    irq_i  = 1'b1;
    wait_rd_issue(ok);
    irq_i  = 1'b0;
    run = 0;
    while (m_stb_o && run < 40) begin
      run++;
      tick();
    end
    check("timeout_stb_cycles", 32'(run), 32'd15);
    check("timeout_err_set", 32'(err_o), 32'h1);
    repeat (4) tick();
    check("timeout_no_retry", 32'(m_stb_o), 32'h0);
    check("timeout_no_vec", 32'(vec_valid_o), 32'h0);
    no_ack = 1'b0;

    service(32'h0000_0600, 2, 1'b0);
    check("err_sticky", 32'(err_o), 32'h1);

    // Reset during the IAR write strobe.
    ipr_val = 32'h0000_0040;
    push_service(32'h0000_0040, 1'b0);
    irq_i = 1'b1;
    wait_rd_issue(ok);
    irq_i = 1'b0;
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (vec_valid_o) vec_ready_i = 1'b1;
      tick();
      vec_ready_i = 1'b0;
      ok = m_stb_o && m_we_o && (m_addr_o == 3'd2);
    end
    check("iar_write_issued", 32'(ok), 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_stb", 32'(m_stb_o), 32'h0);
    check("async_rst_we", 32'(m_we_o), 32'h0);
    check("async_rst_addr", 32'(m_addr_o), 32'h0);
    check("async_rst_dat", m_dat_o, 32'h0);
    check("async_rst_sel", 32'(m_sel_o), 32'h0);
    check("async_rst_err", 32'(err_o), 32'h0);
    check("async_rst_vec", 32'(vec_o), 32'h0);
    check("rst_cleared_queue", 32'(exp_q.size()), 32'h0);
    push_ev(EV_BUS, 1'b1, 3'd1, 32'hFFFF_FFFF);
    push_ev(EV_BUS, 1'b1, 3'd0, 32'h0000_0003);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("restart_ier_stb", 32'(m_stb_o), 32'h1);
    check("restart_ier_addr", 32'(m_addr_o), 32'h1);
    wait_quiet("restart_drain");
    service(32'h0000_0014, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_service_master.md
INT_SERVICE_MASTER -- requirements
Module: int_service_master

Interface
REQ-001 SHALL have parameter INT_NUM, default 32, number of interrupt lines serviced (1..DATA_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-003 SHALL have parameter SEL_WIDTH, default 4, Wishbone byte-select width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 3, Wishbone word-address width.
REQ-005 SHALL have parameter IER_INIT, default all-ones (INT_NUM bits), enable mask written at start-up.
REQ-006 SHALL have parameter ACK_TIMEOUT, default 15, max cycles waiting for m_ack_i (1..255).
REQ-007 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have ports m_dat_o output DATA_WIDTH, m_sel_o output SEL_WIDTH, m_addr_o output ADDR_WIDTH, m_stb_o output 1, m_we_o output 1: Wishbone master request.
REQ-010 SHALL have ports m_dat_i input DATA_WIDTH, m_ack_i input 1: Wishbone master response.
REQ-011 SHALL have port irq_i  input  1  level interrupt request from controller.
REQ-012 SHALL have ports vec_o output log2(INT_NUM) (min 1), vec_valid_o output 1, vec_ready_i input 1: vector handshake to consumer.
REQ-013 SHALL have ports err_o output 1 (sticky bus timeout) and spurious_o output 1 (one-cycle pulse).

Function
REQ-014 Controller register map SHALL be fixed: MER=0, IER=1, IAR=2, IPR=3; m_sel_o SHALL be all-ones during every access.
REQ-015 States SHALL be INIT_IER, INIT_MER, IDLE, RD_IPR, PRESENT, WR_IAR.
REQ-016 Bus access: m_stb_o, m_addr_o, m_we_o, m_dat_o SHALL be held stable from issue until the cycle m_ack_i=1 is sampled; m_stb_o SHALL be 0 the following cycle (no back-to-back strobe, so slave cannot re-ack).
REQ-017 Read data SHALL be captured from m_dat_i[INT_NUM-1:0] in the cycle m_ack_i=1.
REQ-018 After reset: INIT_IER writes IER_INIT to IER; on ack -> INIT_MER writes 2'b11 (zero-extended) to MER; on ack -> IDLE.
REQ-019 IDLE: if irq_i=1 -> RD_IPR (read IPR) next cycle; otherwise remain.
REQ-020 RD_IPR on ack: if captured value nonzero -> PRESENT with vec_o = index of lowest set bit, one-hot mask stored; if zero -> pulse spurious_o one cycle, -> IDLE.
REQ-021 PRESENT: vec_valid_o=1, vec_o stable; transfer when vec_valid_o and vec_ready_i both 1 in same cycle -> WR_IAR next cycle; vec_valid_o SHALL drop next cycle.
REQ-022 WR_IAR: write the stored one-hot mask (zero-extended) to IAR; on ack -> IDLE; irq_i SHALL not be sampled before the IDLE cycle.
REQ-023 Timeout: an 8-bit counter SHALL count cycles with m_stb_o=1 and m_ack_i=0; on reaching ACK_TIMEOUT the access aborts (m_stb_o=0 next cycle), err_o set, state -> IDLE (INIT states retry same write instead). err_o cleared only by reset.
REQ-024 Exactly one access in flight; irq_i changes during RD_IPR/PRESENT/WR_IAR SHALL be ignored.
REQ-025 vec_ready_i high outside PRESENT SHALL have no effect.
REQ-026 Lines above INT_NUM in m_dat_i SHALL be ignored.

Reset
REQ-027 reset=1 SHALL asynchronously force: state INIT_IER, m_stb_o=0, m_we_o=0, m_addr_o=0, m_dat_o=0, m_sel_o=0, vec_o=0, vec_valid_o=0, err_o=0, spurious_o=0, timeout counter 0, stored mask 0.
REQ-028 Reset mid-access SHALL abandon the transaction; first access after release SHALL be the IER write, issued on the first clk edge after reset deasserts.

Verification
REQ-029 Start-up: release reset, slave acks 1 cycle after stb -> writes (addr 1, data 0xFFFFFFFF) then (addr 0, data 0x3), stb low between them, IDLE reached.
REQ-030 Service: irq_i=1, IPR read returns 0x0000_0014 -> vec_o=2, vec_valid_o=1; vec_ready_i=1 -> IAR write data 0x0000_0004; IDLE.
REQ-031 Backpressure: vec_ready_i=0 for 10 cycles -> vec_valid_o=1, vec_o stable, no bus activity; then ready=1 -> single IAR write.
REQ-032 Spurious: IPR read returns 0 -> spurious_o one-cycle pulse, no vec_valid_o, no IAR write.
REQ-033 Timeout: no ack on IPR read -> stb high exactly 15 cycles, err_o=1 sticky, IDLE; later normal service still completes.
REQ-034 Reset asserted during WR_IAR strobe -> all outputs zero immediately (asynchronous), IER write restarts after release.
